// File: rtl/brm_alu_controller.sv
// brm_alu_controller: multi-cycle Moore sequencer that drives the 16-bit
// register-file / shifter / ALU datapath for MOV, ADD, CMP, AND and MVN.
module brm_alu_controller #(
    parameter int INSTR_W        = 16,
    parameter bit ERR_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s,
    input  logic               load,
    input  logic [INSTR_W-1:0] in,
    output logic               w,
    output logic               err,
    output logic [2:0]         nsel,
    output logic [2:0]         readnum,
    output logic [2:0]         writenum,
    output logic               loada,
    output logic               loadb,
    output logic               asel,
    output logic               bsel,
    output logic [1:0]         ALUop,
    output logic [1:0]         shift,
    output logic               loadc,
    output logic               loads,
    output logic [1:0]         vsel,
    output logic               write,
    output logic [15:0]        sximm8
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_STATUS,
        S_WR_IMM,
        S_WR_REG
    } state_e;

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               err_q, err_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic       is_mvn;

    assign opcode     = ir_q[15:13];
    assign op         = ir_q[12:11];
    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    // IR and err only change in WAIT/DECODE, so a load mid-op is dropped
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        err_d   = err_q;
        unique case (state_q)
            S_WAIT: begin
                if (load) begin
                    ir_d = in;
                end
                if (s) begin
                    state_d = S_DECODE;
                    err_d   = 1'b0;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_d = S_WR_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_d = S_GET_B;
                end else if (is_alu) begin
                    state_d = S_GET_A;
                end else begin
                    state_d = S_WAIT;
                    err_d   = ERR_ON_ILLEGAL;
                end
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = is_cmp ? S_STATUS : S_EXEC;
            S_EXEC:   state_d = S_WR_REG;
            S_STATUS: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            S_WR_REG: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        w     = 1'b0;
        nsel  = 3'b000;
        loada = 1'b0;
        loadb = 1'b0;
        asel  = 1'b0;
        ALUop = 2'b00;
        shift = 2'b00;
        loadc = 1'b0;
        loads = 1'b0;
        vsel  = 2'b00;
        write = 1'b0;
        unique case (state_q)
            S_WAIT: w = 1'b1;
            S_GET_A: begin
                nsel  = 3'b001;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = 3'b100;
                loadb = 1'b1;
            end
            S_EXEC: begin
                ALUop = is_mov_reg ? 2'b00 : op;
                asel  = is_mov_reg || is_mvn;
                shift = ir_q[4:3];
                loadc = 1'b1;
            end
            S_STATUS: begin
                ALUop = 2'b01;
                shift = ir_q[4:3];
                loads = 1'b1;
            end
            S_WR_IMM: begin
                nsel  = 3'b001;
                vsel  = 2'b10;
                write = 1'b1;
            end
            S_WR_REG: begin
                nsel  = 3'b010;
                write = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        readnum = 3'b000;
        unique case (1'b1)
            nsel[0]: readnum = ir_q[10:8];
            nsel[1]: readnum = ir_q[7:5];
            nsel[2]: readnum = ir_q[2:0];
            default: readnum = 3'b000;
        endcase
    end

    assign writenum = readnum;
    assign bsel     = 1'b0;
    assign err      = err_q;
    assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_brm_alu_controller.sv
// tb_brm_alu_controller: randomized instruction streams checked cycle by
// cycle against a per-instruction expected-trace model.
module tb_brm_alu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;

    logic        w, err, loada, loadb, asel, bsel, loadc, loads, write;
    logic [2:0]  nsel, readnum, writenum;
    logic [1:0]  ALUop, shift, vsel;
    logic [15:0] sximm8;

    logic        x_w, x_err, x_loada, x_loadb, x_asel, x_bsel;
    logic        x_loadc, x_loads, x_write;
    logic [2:0]  x_nsel, x_readnum, x_writenum;
    logic [1:0]  x_ALUop, x_shift, x_vsel;
    logic [15:0] x_sximm8;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ir_m = 16'h0000;
    bit          err_m = 1'b0;
    logic [38:0] expq[$];

    always #5 clk = ~clk;

    brm_alu_controller #(.INSTR_W(16), .ERR_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .err(err), .nsel(nsel), .readnum(readnum),
        .writenum(writenum), .loada(loada), .loadb(loadb),
        .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift),
        .loadc(loadc), .loads(loads), .vsel(vsel), .write(write),
        .sximm8(sximm8)
    );

    brm_alu_controller #(.INSTR_W(16), .ERR_ON_ILLEGAL(1'b0)) dut_noerr (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(x_w), .err(x_err), .nsel(x_nsel), .readnum(x_readnum),
        .writenum(x_writenum), .loada(x_loada), .loadb(x_loadb),
        .asel(x_asel), .bsel(x_bsel), .ALUop(x_ALUop), .shift(x_shift),
        .loadc(x_loadc), .loads(x_loads), .vsel(x_vsel), .write(x_write),
        .sximm8(x_sximm8)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [38:0] pack();
        return {w, nsel, readnum, writenum, loada, loadb, asel, bsel,
                ALUop, shift, loadc, loads, vsel, write, sximm8};
    endfunction

    function automatic logic [38:0] vec(
        input bit w_e, input logic [2:0] ns, input logic [2:0] rnum,
        input bit la, input bit lb, input bit as, input logic [1:0] aop,
        input logic [1:0] sh, input bit lc, input bit ls,
        input logic [1:0] vs, input bit wr, input logic [15:0] sx);
        return {w_e, ns, rnum, rnum, la, lb, as, 1'b0,
                aop, sh, lc, ls, vs, wr, sx};
    endfunction

    function automatic bit illegal(input logic [15:0] ir);
        return !(ir[15:11] == 5'b11010 || ir[15:11] == 5'b11000 ||
                 ir[15:13] == 3'b101);
    endfunction

    // expected outputs for cycles 1..N after the accepting s edge
    function automatic void build(input logic [15:0] ir);
        logic [15:0] sx;
        logic [1:0]  op;
        logic [1:0]  sh;
        sx = 16'($signed(ir[7:0]));
        op = ir[12:11];
        sh = ir[4:3];
        expq.delete();
        expq.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sx));
        if (ir[15:11] == 5'b11010) begin
            expq.push_back(vec(0, 3'b001, ir[10:8], 0, 0, 0, 0, 0,
                               0, 0, 2'b10, 1, sx));
        end else if (ir[15:11] == 5'b11000) begin
            expq.push_back(vec(0, 3'b100, ir[2:0], 0, 1, 0, 0, 0,
                               0, 0, 0, 0, sx));
            expq.push_back(vec(0, 0, 0, 0, 0, 1, 2'b00, sh,
                               1, 0, 0, 0, sx));
            expq.push_back(vec(0, 3'b010, ir[7:5], 0, 0, 0, 0, 0,
                               0, 0, 2'b00, 1, sx));
        end else if (ir[15:13] == 3'b101) begin
            if (op != 2'b11)
                expq.push_back(vec(0, 3'b001, ir[10:8], 1, 0, 0, 0, 0,
                                   0, 0, 0, 0, sx));
            expq.push_back(vec(0, 3'b100, ir[2:0], 0, 1, 0, 0, 0,
                               0, 0, 0, 0, sx));
            if (op == 2'b01) begin
                expq.push_back(vec(0, 0, 0, 0, 0, 0, 2'b01, sh,
                                   0, 1, 0, 0, sx));
            end else begin
                expq.push_back(vec(0, 0, 0, 0, 0, op == 2'b11, op, sh,
                                   1, 0, 0, 0, sx));
                expq.push_back(vec(0, 3'b010, ir[7:5], 0, 0, 0, 0, 0,
                                   0, 0, 2'b00, 1, sx));
            end
        end
        expq.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sx));
    endfunction

    // called at a negedge with the DUT in WAIT; ends at a WAIT negedge
    task automatic run(input logic [15:0] word, input bit do_load,
                       input bit junk);
        bit ill;
        if (do_load) ir_m = word;
        build(ir_m);
        ill  = illegal(ir_m);
        s    = 1'b1;
        load = do_load;
        in   = word;
        for (int k = 0; k < expq.size(); k++) begin
            @(negedge clk);
            check($sformatf("ir=%h c%0d", ir_m, k + 1), pack(), expq[k]);
            check($sformatf("ir=%h c%0d err", ir_m, k + 1), err,
                  (k == 0) ? 1'b0 : ill);
            check("noerr err", x_err, 0);
            if (junk && k + 1 < expq.size()) begin
                s    = 1'($urandom);
                load = 1'($urandom);
                in   = 16'($urandom);
            end else begin
                s    = 1'b0;
                load = 1'b0;
            end
        end
        err_m = ill;
    endtask

    task automatic idle(input int n);
        s = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle outs", pack(),
                  vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      16'($signed(ir_m[7:0]))));
            check("idle err", err, err_m);
        end
    endtask

    initial begin
        reset = 1'b1;
        s     = 1'b0;
        load  = 1'b0;
        in    = 16'h0000;
        #2;
        check("rst outs", pack(), vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("rst err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        run(16'hD0FB, 1, 0);
        check("sximm8 -5", sximm8, 16'hFFFB);
        run(16'hA248, 1, 0);
        run(16'hA900, 1, 0);
        run(16'hE000, 1, 0);
        idle(3);
        run(16'hD0FB, 1, 0);
        run(16'hC0B3, 1, 1);
        run(16'hC0B3, 0, 1);

        // async reset while ADD sits in EXEC
        s    = 1'b1;
        load = 1'b1;
        in   = 16'hA248;
        repeat (4) @(posedge clk);
        s    = 1'b0;
        load = 1'b0;
        @(negedge clk);
        build(16'hA248);
        check("pre-rst exec", pack(), expq[3]);
        #2 reset = 1'b1;
        #1;
        check("mid rst w", w, 1);
        check("mid rst loadc", loadc, 0);
        check("mid rst outs", pack(),
              vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("mid rst err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        ir_m  = 16'h0000;
        err_m = 1'b0;
        run(16'h0000, 0, 0);
        run(16'hA900, 1, 0);

        for (int i = 0; i < 200; i++) begin
            logic [15:0] r;
            int          pick;
            r    = 16'($urandom);
            pick = $urandom_range(0, 6);
            case (pick)
                0: run({5'b11010, r[10:0]}, 1, 1'($urandom));
                1: run({5'b11000, r[10:0]}, 1, 1'($urandom));
                2, 3: run({3'b101, r[12:0]}, 1, 1'($urandom));
                4: run(r, 1, 1'($urandom));
                5: run(r, 0, 1'($urandom));
                default: idle($urandom_range(1, 3));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
